// File: rtl/shr8_serial.sv
// rtl/shr8_serial.sv - sequential right shifter (LSR/ASR, ROR when SHR8_ROR_EN), one bit per clock
// Optional rotate mode is enabled by defining SHR8_ROR_EN.
module shr8_serial #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic [WIDTH-1:0]   d_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   data, data_n;
  logic [SHAMT_W-1:0] cnt, cnt_n;
  logic [1:0]         op_r, op_r_n;

  // Only the fill bit entering at the top differs between modes.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic [1:0] m);
    logic fill;
    fill = 1'b0;
    case (m)
      2'b01:   fill = v[WIDTH-1];
`ifdef SHR8_ROR_EN
      2'b10:   fill = v[0];
`endif
      default: fill = 1'b0;
    endcase
    return {fill, v[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      data  <= '0;
      cnt   <= '0;
      op_r  <= 2'b00;
    end else begin
      state <= state_n;
      data  <= data_n;
      cnt   <= cnt_n;
      op_r  <= op_r_n;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data;
    cnt_n   = cnt;
    op_r_n  = op_r;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_SHIFT;
          data_n  = d_in;
          cnt_n   = shamt;
          op_r_n  = op;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SHIFT: begin
        // The count never underflows: the cnt==0 cycle only hands over to DONE.
        if (cnt != '0) begin
          data_n = shift1(data, op_r);
          cnt_n  = cnt - 1'b1;
        end else begin
          state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign d_out = data;
  assign busy  = (state == S_SHIFT);
  assign done  = (state == S_DONE);

endmodule
